// File: rtl/cp0_defs.sv
// Shared CP0 definitions: Status/Cause bit positions, ExcCodes, sequencer state encoding
// and the latched event payload used by the exception controller.
package cp0_defs;

    localparam int unsigned IE     = 0;
    localparam int unsigned EXL    = 1;
    localparam int unsigned IM_LO  = 8;
    localparam int unsigned IM_HI  = 15;
    localparam int unsigned BD     = 31;
    localparam int unsigned IP_LO  = 8;
    localparam int unsigned IP_HI  = 15;
    localparam int unsigned EXC_LO = 2;
    localparam int unsigned EXC_HI = 6;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned EXC_CODE_W = 5;

    localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_CODE_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [EXC_CODE_W-1:0] EXC_BP   = 5'd9;
    localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } exc_state_t;

    typedef enum logic [1:0] {
        EV_EXC  = 2'd0,
        EV_INT  = 2'd1,
        EV_ERET = 2'd2
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t                kind;
        logic [EXC_CODE_W-1:0]   code;
        logic [XLEN-1:0]         pc;
        logic                    bd;
        logic [XLEN-1:0]         status;
        logic [XLEN-1:0]         cause;
        logic [XLEN-1:0]         epc;
    } exc_evt_t;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser for asynchronous interrupt request lines.
module int_sync #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: accepts one event, then flushes the pipeline,
// commits Status/Cause/EPC and redirects fetch, one step per cycle.
module exc_ctrl
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int unsigned INT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic [INT_WIDTH-1:0]  int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic                  eret_i,
    input  logic [31:0]           cp0_status_i,
    input  logic [31:0]           cp0_cause_i,
    input  logic [31:0]           cp0_epc_i,
    output logic [31:0]           cp0_status_o,
    output logic                  cp0_status_wen_o,
    output logic [31:0]           cp0_cause_o,
    output logic                  cp0_cause_wen_o,
    output logic [31:0]           cp0_epc_o,
    output logic                  cp0_epc_wen_o,
    output logic [INT_WIDTH-1:0]  ip_o,
    output logic                  flush_o,
    output logic                  redirect_o,
    output logic [31:0]           redirect_pc_o,
    output logic                  busy_o
);

    localparam int unsigned IRQ_W = 8;

    exc_state_t state, next_state;
    exc_evt_t   lat, evt_d;

    logic              int_pend;
    logic              take;
    logic              flush_d;
    logic              commit_d;
    logic              redirect_d;
    logic [31:0]       status_d;
    logic [31:0]       cause_d;
    logic [31:0]       epc_d;
    logic              epc_wen_d;
    logic              cause_wen_d;
    logic [IRQ_W-1:0]  irq_lines;

    int_sync #(.WIDTH(INT_WIDTH)) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (int_i),
        .q     (ip_o)
    );

    // Hardware lines occupy IP[15:10], software lines IP[9:8].
    assign irq_lines = IRQ_W'({ip_o, cp0_cause_i[IP_LO+1:IP_LO]});
    assign int_pend  = cp0_status_i[IE] & ~cp0_status_i[EXL]
                     & (|(irq_lines & cp0_status_i[IM_HI:IM_LO]));

    // Event priority: synchronous exception, then interrupt, then ERET.
    always_comb begin
        evt_d        = '0;
        evt_d.pc     = exc_pc_i;
        evt_d.bd     = exc_bd_i;
        evt_d.status = cp0_status_i;
        evt_d.cause  = cp0_cause_i;
        evt_d.epc    = cp0_epc_i;
        evt_d.code   = exc_code_i;
        evt_d.kind   = EV_EXC;
        if (!exc_valid_i) begin
            if (int_pend) begin
                evt_d.kind = EV_INT;
                evt_d.code = EXC_INT;
            end else begin
                evt_d.kind = EV_ERET;
                evt_d.code = '0;
            end
        end
    end

    // CP0 write-back values derived from the latched event.
    always_comb begin
        status_d    = lat.status;
        cause_d     = lat.cause;
        epc_d       = lat.epc;
        epc_wen_d   = 1'b0;
        cause_wen_d = 1'b0;
        if (lat.kind == EV_ERET) begin
            status_d[EXL] = 1'b0;
        end else begin
            status_d[EXL]            = 1'b1;
            cause_d[EXC_HI:EXC_LO]   = lat.code;
            cause_wen_d              = 1'b1;
            if (!lat.status[EXL]) begin
                cause_d[BD] = lat.bd;
                epc_d       = lat.bd ? 32'(lat.pc - 32'd4) : lat.pc;
                epc_wen_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // COMMIT leaves once the registered write strobe has been issued.
    always_comb begin
        next_state = state;
        take       = 1'b0;
        flush_d    = 1'b0;
        commit_d   = 1'b0;
        redirect_d = 1'b0;
        case (state)
            IDLE: begin
                if (!pause && (exc_valid_i || int_pend || eret_i)) begin
                    take       = 1'b1;
                    flush_d    = 1'b1;
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                commit_d   = ~pause;
                next_state = COMMIT;
            end
            COMMIT: begin
                if (cp0_status_wen_o) begin
                    redirect_d = 1'b1;
                    next_state = REDIRECT;
                end else begin
                    commit_d = ~pause;
                end
            end
            REDIRECT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lat              <= '0;
            flush_o          <= 1'b0;
            redirect_o       <= 1'b0;
            redirect_pc_o    <= '0;
            busy_o           <= 1'b0;
            cp0_status_o     <= '0;
            cp0_status_wen_o <= 1'b0;
            cp0_cause_o      <= '0;
            cp0_cause_wen_o  <= 1'b0;
            cp0_epc_o        <= '0;
            cp0_epc_wen_o    <= 1'b0;
        end else begin
            flush_o          <= flush_d;
            redirect_o       <= redirect_d;
            busy_o           <= (next_state != IDLE);
            cp0_status_wen_o <= commit_d;
            cp0_cause_wen_o  <= commit_d & cause_wen_d;
            cp0_epc_wen_o    <= commit_d & epc_wen_d;
            if (take) begin
                lat <= evt_d;
            end
            if (commit_d) begin
                cp0_status_o <= status_d;
                cp0_cause_o  <= cause_d;
                if (epc_wen_d) begin
                    cp0_epc_o <= epc_d;
                end
            end
            if (redirect_d) begin
                redirect_pc_o <= (lat.kind == EV_ERET) ? lat.epc : EXC_VECTOR;
            end
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: exception, interrupt, ERET, pause and reset sequences.
module tb_exc_ctrl;
    import cp0_defs::*;

    localparam int unsigned INT_WIDTH = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 pause;
    logic [INT_WIDTH-1:0] int_i;
    logic                 exc_valid_i;
    logic [4:0]           exc_code_i;
    logic [31:0]          exc_pc_i;
    logic                 exc_bd_i;
    logic                 eret_i;
    logic [31:0]          cp0_status_i;
    logic [31:0]          cp0_cause_i;
    logic [31:0]          cp0_epc_i;
    logic [31:0]          cp0_status_o;
    logic                 cp0_status_wen_o;
    logic [31:0]          cp0_cause_o;
    logic                 cp0_cause_wen_o;
    logic [31:0]          cp0_epc_o;
    logic                 cp0_epc_wen_o;
    logic [INT_WIDTH-1:0] ip_o;
    logic                 flush_o;
    logic                 redirect_o;
    logic [31:0]          redirect_pc_o;
    logic                 busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    exc_ctrl #(.EXC_VECTOR(32'hBFC00380), .INT_WIDTH(INT_WIDTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .pause            (pause),
        .int_i            (int_i),
        .exc_valid_i      (exc_valid_i),
        .exc_code_i       (exc_code_i),
        .exc_pc_i         (exc_pc_i),
        .exc_bd_i         (exc_bd_i),
        .eret_i           (eret_i),
        .cp0_status_i     (cp0_status_i),
        .cp0_cause_i      (cp0_cause_i),
        .cp0_epc_i        (cp0_epc_i),
        .cp0_status_o     (cp0_status_o),
        .cp0_status_wen_o (cp0_status_wen_o),
        .cp0_cause_o      (cp0_cause_o),
        .cp0_cause_wen_o  (cp0_cause_wen_o),
        .cp0_epc_o        (cp0_epc_o),
        .cp0_epc_wen_o    (cp0_epc_wen_o),
        .ip_o             (ip_o),
        .flush_o          (flush_o),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        exc_valid_i = 1'b0;
        eret_i      = 1'b0;
        int_i       = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"},     busy_o,           1'b0);
        chk({tag, ".flush"},    flush_o,          1'b0);
        chk({tag, ".st_wen"},   cp0_status_wen_o, 1'b0);
        chk({tag, ".ca_wen"},   cp0_cause_wen_o,  1'b0);
        chk({tag, ".epc_wen"},  cp0_epc_wen_o,    1'b0);
        chk({tag, ".redirect"}, redirect_o,       1'b0);
    endtask

    // Event is already on the inputs for the current (accept) cycle.
    task automatic expect_seq(input string tag, input logic [31:0] st, input logic ew,
                              input logic [31:0] epc, input logic cw, input logic [31:0] cause,
                              input logic [31:0] rpc);
        tick();
        clear_events();
        chk({tag, ".f.flush"},  flush_o,          1'b1);
        chk({tag, ".f.busy"},   busy_o,           1'b1);
        chk({tag, ".f.st_wen"}, cp0_status_wen_o, 1'b0);
        tick();
        chk({tag, ".c.flush"},   flush_o,          1'b0);
        chk({tag, ".c.st_wen"},  cp0_status_wen_o, 1'b1);
        chk({tag, ".c.status"},  cp0_status_o,     st);
        chk({tag, ".c.epc_wen"}, cp0_epc_wen_o,    ew);
        if (ew) chk({tag, ".c.epc"}, cp0_epc_o, epc);
        chk({tag, ".c.ca_wen"},  cp0_cause_wen_o,  cw);
        if (cw) chk({tag, ".c.cause"}, cp0_cause_o, cause);
        chk({tag, ".c.redirect"}, redirect_o,      1'b0);
        tick();
        chk({tag, ".r.redirect"}, redirect_o,       1'b1);
        chk({tag, ".r.pc"},       redirect_pc_o,    rpc);
        chk({tag, ".r.st_wen"},   cp0_status_wen_o, 1'b0);
        chk({tag, ".r.busy"},     busy_o,           1'b1);
        tick();
        chk({tag, ".i.busy"},     busy_o,     1'b0);
        chk({tag, ".i.redirect"}, redirect_o, 1'b0);
    endtask

    task automatic drive_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
        exc_valid_i = 1'b1;
        exc_code_i  = code;
        exc_pc_i    = pc;
        exc_bd_i    = bd;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b0;
        pause        = 1'b0;
        clear_events();
        exc_code_i   = '0;
        exc_pc_i     = 32'h8000_0000;
        exc_bd_i     = 1'b0;
        cp0_status_i = '0;
        cp0_cause_i  = '0;
        cp0_epc_i    = '0;
        tick();
        tick();
        chk_quiet("reset");
        chk("reset.status", cp0_status_o,  32'h0);
        chk("reset.rpc",    redirect_pc_o, 32'h0);
        chk("reset.ip",     32'(ip_o),     32'h0);
        reset = 1'b1;
        tick();

        // Syscall, not in a delay slot
        cp0_status_i = 32'h0000_0001;
        drive_exc(EXC_SYS, 32'h8000_0100, 1'b0);
        expect_seq("sys", 32'h0000_0003, 1'b1, 32'h8000_0100, 1'b1, 32'h0000_0020, 32'hBFC0_0380);

        // Overflow in a branch delay slot
        drive_exc(EXC_OV, 32'h8000_0204, 1'b1);
        expect_seq("bd", 32'h0000_0003, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0030, 32'hBFC0_0380);

        // Hardware interrupt 0 through the synchroniser
        cp0_status_i = 32'h0000_0401;
        exc_pc_i     = 32'h8000_0400;
        exc_bd_i     = 1'b0;
        int_i        = 6'b000001;
        tick();
        chk("irq.ip_s1",   32'(ip_o), 32'h0);
        chk("irq.busy_s1", busy_o,    1'b0);
        tick();
        chk("irq.ip_s2",   32'(ip_o), 32'h1);
        chk("irq.busy_s2", busy_o,    1'b0);
        expect_seq("irq", 32'h0000_0403, 1'b1, 32'h8000_0400, 1'b1, 32'h0000_0000, 32'hBFC0_0380);
        tick();
        tick();

        // Same interrupt with EXL already set is masked
        cp0_status_i = 32'h0000_0403;
        int_i        = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("irq_exl.busy", busy_o, 1'b0);
        end
        chk("irq_exl.ip", 32'(ip_o), 32'h1);
        int_i = '0;
        tick();
        tick();
        tick();

        // Nested exception: EPC kept, BD kept, ExcCode updated
        cp0_status_i = 32'h0000_0003;
        cp0_cause_i  = 32'h8000_0020;
        drive_exc(EXC_RI, 32'h8000_0500, 1'b0);
        expect_seq("nest", 32'h0000_0003, 1'b0, 32'h0, 1'b1, 32'h8000_0028, 32'hBFC0_0380);

        // ERET
        cp0_cause_i  = 32'h0;
        cp0_status_i = 32'h0000_0003;
        cp0_epc_i    = 32'h8000_0300;
        eret_i       = 1'b1;
        expect_seq("eret", 32'h0000_0001, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8000_0300);

        // ERET together with an exception: exception wins
        eret_i = 1'b1;
        drive_exc(EXC_SYS, 32'h8000_0310, 1'b0);
        expect_seq("eret_exc", 32'h0000_0003, 1'b0, 32'h0, 1'b1, 32'h0000_0020, 32'hBFC0_0380);

        // Pause blocks acceptance in IDLE and holds COMMIT
        cp0_status_i = 32'h0000_0001;
        pause        = 1'b1;
        drive_exc(EXC_ADEL, 32'h8000_0600, 1'b0);
        tick();
        chk("pause.idle_busy", busy_o, 1'b0);
        pause = 1'b0;
        tick();
        clear_events();
        chk("pause.flush", flush_o, 1'b1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause.hold_wen",  cp0_status_wen_o, 1'b0);
            chk("pause.hold_epc",  cp0_epc_wen_o,    1'b0);
            chk("pause.hold_busy", busy_o,           1'b1);
            if (i == 2) pause = 1'b0;
        end
        tick();
        chk("pause.st_wen", cp0_status_wen_o, 1'b1);
        chk("pause.status", cp0_status_o,     32'h0000_0003);
        chk("pause.epc",    cp0_epc_o,        32'h8000_0600);
        chk("pause.cause",  cp0_cause_o,      32'h0000_0010);
        tick();
        chk("pause.redirect", redirect_o,    1'b1);
        chk("pause.rpc",      redirect_pc_o, 32'hBFC0_0380);
        tick();
        chk("pause.end_busy", busy_o, 1'b0);

        // Reset during FLUSH abandons the sequence
        drive_exc(EXC_BP, 32'h8000_0700, 1'b0);
        tick();
        clear_events();
        chk("rstmid.flush", flush_o, 1'b1);
        reset = 1'b0;
        tick();
        chk_quiet("rstmid.r");
        chk("rstmid.rpc", redirect_pc_o, 32'h0);
        reset = 1'b1;
        tick();
        chk_quiet("rstmid.a");
        tick();
        chk_quiet("rstmid.b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
